// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory bus for pc_fetch_sequencer: level request with a word address,
// answered by a one-cycle acknowledge that carries the instruction word.
interface pc_fetch_sequencer_if;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch-side controller owning the architectural PC (word address) and sequencing fetches.
// Define NPC_JR_EN to enable register jump (npc_op 2'b11 -> rs_val[31:2]).
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_3000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_fetch_sequencer_if.master imem,
    output logic [31:0]          instr_o,
    output logic                 instr_valid_o,
    output logic [29:0]          pc_o,
    input  logic                 npc_valid_i,
    input  logic [1:0]           npc_op_i,
    input  logic [25:0]          npc_imm_i,
    input  logic [31:0]          rs_val_i,
    input  logic                 stall_i,
    output logic                 fetch_err_o
);

    localparam int unsigned      CNT_W    = $clog2(FETCH_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECIDE,
        S_STALL
    } state_e;

    state_e           state_q;
    logic [29:0]      pc_q;
    logic [29:0]      next_pc_d;
    logic             req_q;
    logic [31:0]      instr_q;
    logic             instr_valid_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       pend_op_q;
    logic [25:0]      pend_imm_q;
    logic [1:0]       sel_op;
    logic [25:0]      sel_imm;

`ifdef NPC_JR_EN
    logic [29:0]      pend_rs_q;
    logic [29:0]      sel_rs;
    logic             unused_rs_lo;
    assign unused_rs_lo = ^rs_val_i[1:0];
`else
    logic             unused_rs;
    assign unused_rs = ^rs_val_i;
`endif

    // In S_STALL the decision comes from the pending register, otherwise straight from decode.
    always_comb begin
        sel_op  = npc_op_i;
        sel_imm = npc_imm_i;
`ifdef NPC_JR_EN
        sel_rs  = rs_val_i[31:2];
`endif
        if (state_q == S_STALL) begin
            sel_op  = pend_op_q;
            sel_imm = pend_imm_q;
`ifdef NPC_JR_EN
            sel_rs  = pend_rs_q;
`endif
        end

        next_pc_d = pc_q + 30'd1;
        case (sel_op)
            2'b01:   next_pc_d = pc_q + {{14{sel_imm[15]}}, sel_imm[15:0]};
            2'b10:   next_pc_d = {pc_q[29:26], sel_imm};
`ifdef NPC_JR_EN
            2'b11:   next_pc_d = sel_rs;
`endif
            default: next_pc_d = pc_q + 30'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC[31:2];
            req_q         <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            pend_op_q     <= '0;
            pend_imm_q    <= '0;
`ifdef NPC_JR_EN
            pend_rs_q     <= '0;
`endif
        end else begin
            instr_valid_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    // A low request (after reset, a decision or a timeout) re-arms for one cycle first.
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem.imem_ack) begin
                        instr_q       <= imem.imem_rdata;
                        instr_valid_q <= 1'b1;
                        req_q         <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= S_DECIDE;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q <= 1'b0;
                        cnt_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DECIDE: begin
                    if (npc_valid_i) begin
                        if (!stall_i) begin
                            pc_q    <= next_pc_d;
                            state_q <= S_FETCH;
                        end else begin
                            pend_op_q  <= npc_op_i;
                            pend_imm_q <= npc_imm_i;
`ifdef NPC_JR_EN
                            pend_rs_q  <= rs_val_i[31:2];
`endif
                            state_q    <= S_STALL;
                        end
                    end
                end
                S_STALL: begin
                    if (!stall_i) begin
                        pc_q    <= next_pc_d;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr_o        = instr_q;
    assign instr_valid_o  = instr_valid_q;
    assign pc_o           = pc_q;
    assign fetch_err_o    = err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a next-PC model in plain arithmetic tracks the
// expected PC and is compared against the DUT every cycle, with literal anchors per scenario.
module tb_pc_fetch_sequencer;

`ifdef NPC_JR_EN
    localparam bit JR_EN = 1'b1;
`else
    localparam bit JR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        npc_valid;
    logic [1:0]  npc_op;
    logic [25:0] npc_imm;
    logic [31:0] rs_val;
    logic        stall;
    logic        ack_en;
    logic [31:0] instr;
    logic        instr_valid;
    logic [29:0] pc;
    logic        fetch_err;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [29:0] m_pc;
    logic        m_err;
    bit          chk_en    = 1'b0;
    bit          err_known = 1'b1;
    int unsigned cyc       = 0;
    int unsigned iv_cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b01} ^ 32'hA5A5_0000;
    endfunction

    pc_fetch_sequencer_if imem_bus ();
    assign imem_bus.imem_ack   = ack_en & imem_bus.imem_req;
    assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

    pc_fetch_sequencer #(
        .RESET_PC      (32'h0000_3000),
        .FETCH_TIMEOUT (16)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem_bus),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .pc_o          (pc),
        .npc_valid_i   (npc_valid),
        .npc_op_i      (npc_op),
        .npc_imm_i     (npc_imm),
        .rs_val_i      (rs_val),
        .stall_i       (stall),
        .fetch_err_o   (fetch_err)
    );

    // Next PC straight from the decoder rules, modulo 2^30.
    function automatic logic [29:0] model_next(input logic [29:0] p, input logic [1:0] op,
                                               input logic [25:0] imm, input logic [31:0] rs);
        int off;
        case (op)
            2'd1: begin
                off = int'(imm[15:0]);
                if (off >= 32768) off -= 65536;
                return 30'(int'(p) + off);
            end
            2'd2:    return (p & 30'h3C00_0000) | 30'(imm);
            2'd3:    return JR_EN ? 30'(rs >> 2) : p + 30'd1;
            default: return p + 30'd1;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", 32'(pc), 32'(m_pc));
            if (imem_bus.imem_req) check("imem_addr", 32'(imem_bus.imem_addr), 32'(m_pc));
            if (err_known) check("fetch_err", 32'(fetch_err), 32'(m_err));
            if (instr_valid) check("instr", instr, mem_word(m_pc));
        end
    end

    task automatic wait_req(input string name);
        int n = 0;
        @(negedge clk);
        while (!imem_bus.imem_req && n < 60) begin
            n++;
            @(negedge clk);
        end
        check({name, " req"}, 32'(imem_bus.imem_req), 32'd1);
    endtask

    task automatic expect_fetch(input string name, input logic [29:0] addr);
        wait_req(name);
        check(name, 32'(imem_bus.imem_addr), 32'(addr));
    endtask

    // Decode answers after instr_valid; decisions offered while fetching or stalled must be ignored.
    task automatic decide(input logic [1:0] op, input logic [25:0] imm, input logic [31:0] rs,
                          input int stall_cyc);
        int n = 0;
        npc_valid = 1'b1;
        npc_op    = 2'b01;
        npc_imm   = 26'h000_1234;
        stall     = 1'b0;
        @(negedge clk);
        while (!instr_valid && n < 60) begin
            n++;
            @(negedge clk);
        end
        check("instr_valid seen", 32'(instr_valid), 32'd1);
        iv_cyc  = cyc;
        npc_op  = op;
        npc_imm = imm;
        rs_val  = rs;
        stall   = (stall_cyc > 0);
        @(posedge clk);
        #1;
        if (stall_cyc > 0) begin
            npc_op  = 2'b10;
            npc_imm = 26'h3FF_FFFF;
            rs_val  = '1;
            for (int i = 1; i < stall_cyc; i++) begin
                @(posedge clk);
                #1;
            end
            stall = 1'b0;
            @(posedge clk);
            #1;
        end
        npc_valid = 1'b0;
        m_pc = model_next(m_pc, op, imm, rs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned t0;
        int          n;
        rst = 1'b1; npc_valid = 1'b0; npc_op = '0; npc_imm = '0; rs_val = '0; stall = 1'b0;
        ack_en = 1'b1; m_pc = 30'h0C00; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset imem_req", 32'(imem_bus.imem_req), 32'd0);
        check("reset pc", 32'(pc), 32'h0C00);
        check("reset fetch_err", 32'(fetch_err), 32'd0);
        check("reset instr_valid", 32'(instr_valid), 32'd0);
        check("reset instr", instr, 32'd0);

        expect_fetch("seq addr0", 30'h0C00); decide(2'd0, '0, '0, 0); t0 = iv_cyc;
        expect_fetch("seq addr1", 30'h0C01); decide(2'd0, '0, '0, 0);
        check("instr_valid spacing 1", iv_cyc - t0, 32'd3); t0 = iv_cyc;
        expect_fetch("seq addr2", 30'h0C02); decide(2'd0, '0, '0, 0);
        check("instr_valid spacing 2", iv_cyc - t0, 32'd3);
        expect_fetch("seq addr3", 30'h0C03); decide(2'd0, '0, '0, 0);
        expect_fetch("seq addr4", 30'h0C04); decide(2'd0, '0, '0, 0);

        expect_fetch("pc C05", 30'h0C05);    decide(2'd1, 26'h000_FFFE, '0, 0);
        expect_fetch("branch -2", 30'h0C03); decide(2'd0, '0, '0, 0);
        expect_fetch("seq C04", 30'h0C04);   decide(2'd0, '0, '0, 0);
        expect_fetch("pc C05 again", 30'h0C05); decide(2'd1, 26'h000_0004, '0, 0);
        expect_fetch("branch +4", 30'h0C09);

        decide(2'd1, 26'h000_0001, '0, 5);
        @(negedge clk);
        check("addr after stall release", 32'(imem_bus.imem_addr), 32'h0C0A);
        expect_fetch("stalled branch +1", 30'h0C0A);

        decide(2'd2, 26'h000_0123, '0, 0);
        expect_fetch("jump low region", 30'h0000_0123); decide(2'd1, 26'h000_FEDD, '0, 0);
        expect_fetch("branch to zero", 30'h0);          decide(2'd1, 26'h000_FFFF, '0, 0);
        expect_fetch("branch wraps down", 30'h3FFF_FFFF); decide(2'd0, '0, '0, 0);
        expect_fetch("seq wraps to zero", 30'h0);       decide(2'd1, 26'h000_FFFF, '0, 0);
        expect_fetch("top again", 30'h3FFF_FFFF);       decide(2'd2, 26'h000_0123, '0, 0);
        expect_fetch("jump keeps upper bits", 30'h3C00_0123);
        decide(2'd3, 26'h000_0000, 32'h0000_4007, 0);
        expect_fetch("op 11", JR_EN ? 30'h0000_1001 : 30'h3C00_0124);
        decide(2'd3, 26'h000_0000, 32'h0000_8008, 2);

        ack_en    = 1'b0;
        err_known = 1'b0;
        wait_req("timeout start");
        n = 0;
        while (imem_bus.imem_req && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("req cycles before timeout", n, 32'd16);
        check("req low after timeout", 32'(imem_bus.imem_req), 32'd0);
        check("fetch_err set", 32'(fetch_err), 32'd1);
        @(negedge clk);
        check("req reissued", 32'(imem_bus.imem_req), 32'd1);
        check("reissue addr", 32'(imem_bus.imem_addr), JR_EN ? 32'h0000_2002 : 32'h3C00_0125);
        @(posedge clk);
        #1;
        m_err     = 1'b1;
        err_known = 1'b1;
        repeat (4) @(negedge clk);

        rst    = 1'b1;
        ack_en = 1'b1;
        @(posedge clk);
        #1;
        m_pc  = 30'h0C00;
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid-wait reset pc", 32'(pc), 32'h0C00);
        check("mid-wait reset fetch_err", 32'(fetch_err), 32'd0);
        check("mid-wait reset imem_req", 32'(imem_bus.imem_req), 32'd0);
        check("reset-cycle ack ignored valid", 32'(instr_valid), 32'd0);
        check("reset-cycle ack ignored instr", instr, 32'd0);
        expect_fetch("post-reset addr", 30'h0C00);
        decide(2'd0, '0, '0, 0);
        expect_fetch("post-reset seq", 30'h0C01);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
